// File: rtl/vga_timing.sv
// VGA raster timing: clock divider, horizontal/vertical position counters, registered syncs and visible flag.
// Optional frame counter enabled with VGA_TIMING_FRAME_CNT_EN; otherwise frame_cnt is tied to zero.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       bright,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // 11-bit boundaries so an edge sitting exactly at 1024 still compares correctly
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing: CLK_DIV must be at least 1");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing: horizontal and vertical totals must not exceed 1024");
    end
    if (H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_empty
      $error("vga_timing: horizontal and vertical totals must be non-zero");
    end
  endgenerate

  function automatic logic hsync_at(input logic [9:0] h);
    return !(({1'b0, h} >= HS_START) && ({1'b0, h} < HS_END));
  endfunction

  function automatic logic vsync_at(input logic [9:0] v);
    return !(({1'b0, v} >= VS_START) && ({1'b0, v} < VS_END));
  endfunction

  function automatic logic bright_at(input logic [9:0] h, input logic [9:0] v);
    return ({1'b0, h} < H_VIS_END) && ({1'b0, v} < V_VIS_END);
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             tick;
  logic             tick_nxt;

  // tick is the live pixel strobe; pix_en is its registered copy, both agree every cycle
  always_comb begin
    tick    = (div_cnt == DIV_LAST);
    div_nxt = tick ? '0 : div_cnt + 1'b1;
    h_nxt   = hcount;
    v_nxt   = vcount;
    if (tick) begin
      if (hcount == H_LAST) begin
        h_nxt = 10'd0;
        v_nxt = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      end else begin
        h_nxt = hcount + 10'd1;
      end
    end
    tick_nxt = (div_nxt == DIV_LAST);
  end

  // Decodes use next-state counters so syncs/bright land on the same edge as the counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      hcount      <= 10'd0;
      vcount      <= 10'd0;
      pix_en      <= (CLK_DIV == 1);
      hsync       <= hsync_at(10'd0);
      vsync       <= vsync_at(10'd0);
      bright      <= bright_at(10'd0, 10'd0);
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      pix_en      <= tick_nxt;
      hsync       <= hsync_at(h_nxt);
      vsync       <= vsync_at(v_nxt);
      bright      <= bright_at(h_nxt, v_nxt);
      frame_start <= tick_nxt && (h_nxt == H_LAST) && (v_nxt == V_LAST);
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= 8'd0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Randomized-reset bench for vga_timing: three instances (default timing, small CLK_DIV=3, small CLK_DIV=1)
// compared every cycle against an arithmetic raster model driven by clocks elapsed since reset.
module tb_vga_timing;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic clk;
  logic reset;
  int unsigned t = 0;
  int errors = 0;
  int checks = 0;

  logic       d_pix, s_pix, o_pix;
  logic [9:0] d_h, d_v, s_h, s_v, o_h, o_v;
  logic       d_hs, d_vs, d_br, d_fs;
  logic       s_hs, s_vs, s_br, s_fs;
  logic       o_hs, o_vs, o_br, o_fs;
  logic [7:0] d_fc, s_fc, o_fc;

  vga_timing u_dflt (
    .clk(clk), .reset(reset), .pix_en(d_pix), .hcount(d_h), .vcount(d_v),
    .hsync(d_hs), .vsync(d_vs), .bright(d_br), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(3)
  ) u_small (
    .clk(clk), .reset(reset), .pix_en(s_pix), .hcount(s_h), .vcount(s_v),
    .hsync(s_hs), .vsync(s_vs), .bright(s_br), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  vga_timing #(
    .H_VISIBLE(10), .H_FRONT(1), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .CLK_DIV(1)
  ) u_one (
    .clk(clk), .reset(reset), .pix_en(o_pix), .hcount(o_h), .vcount(o_v),
    .hsync(o_hs), .vsync(o_vs), .bright(o_br), .frame_start(o_fs), .frame_cnt(o_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clocks elapsed since reset released; reset forces it back to zero asynchronously
  always @(posedge clk or posedge reset) begin
    if (reset) t <= 0;
    else       t <= t + 1;
  end

  // Raster position follows from elapsed clocks: pixel index = t / div, then line/frame by division
  function automatic obs_t model(input int unsigned tt, input int hv, input int hf, input int hsw,
                                 input int hb, input int vv, input int vf, input int vsw,
                                 input int vb, input int dv);
    obs_t e;
    int unsigned ht, vt, n, h, v, frames;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    n  = tt / dv;
    h  = n % ht;
    v  = (n / ht) % vt;
    frames = n / (ht * vt);
    e.pix_en = ((tt % dv) == dv - 1);
    e.h  = 10'(h);
    e.v  = 10'(v);
    e.hs = !((h >= hv + hf) && (h < hv + hf + hsw));
    e.vs = !((v >= vv + vf) && (v < vv + vf + vsw));
    e.br = (h < hv) && (v < vv);
    e.fs = e.pix_en && (h == ht - 1) && (v == vt - 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    e.fc = 8'(frames % 256);
`else
    e.fc = 8'd0;
`endif
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0d time=%0t", tag, got, exp, t, $time);
    end
  endtask

  task automatic cmp_all(input string who, input obs_t g, input obs_t e);
    check_val({who, ".pix_en"},      32'(g.pix_en), 32'(e.pix_en));
    check_val({who, ".hcount"},      32'(g.h),      32'(e.h));
    check_val({who, ".vcount"},      32'(g.v),      32'(e.v));
    check_val({who, ".hsync"},       32'(g.hs),     32'(e.hs));
    check_val({who, ".vsync"},       32'(g.vs),     32'(e.vs));
    check_val({who, ".bright"},      32'(g.br),     32'(e.br));
    check_val({who, ".frame_start"}, 32'(g.fs),     32'(e.fs));
    check_val({who, ".frame_cnt"},   32'(g.fc),     32'(e.fc));
  endtask

  task automatic check_all();
    cmp_all("dflt",  {d_pix, d_h, d_v, d_hs, d_vs, d_br, d_fs, d_fc},
            model(t, 640, 16, 96, 48, 480, 10, 2, 33, 2));
    cmp_all("small", {s_pix, s_h, s_v, s_hs, s_vs, s_br, s_fs, s_fc},
            model(t, 16, 2, 4, 3, 8, 2, 2, 3, 3));
    cmp_all("div1",  {o_pix, o_h, o_v, o_hs, o_vs, o_br, o_fs, o_fc},
            model(t, 10, 1, 2, 2, 4, 1, 1, 2, 1));
  endtask

  // Inputs change on the falling edge; sampling 1 time unit later also catches the async reset effect
  task automatic step(input logic r);
    @(negedge clk);
    reset = r;
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) step(1'b1);
    repeat (6000) step(1'b0);
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(1, 4)) step(1'b1);
      repeat ($urandom_range(100, 2500)) step(1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
